// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the matrix multiply accelerator.
//   - default matrix dimension, word and address widths
//   - one-hot state encoding of the memory sequencer
// The controller FSM imports this package for the same widths.
package mm_pkg;

  localparam int MM_N      = 4;
  localparam int MM_DATA_W = 16;
  localparam int MM_ADDR_W = 8;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_RD_A = 5'b00010,
    ST_RD_B = 5'b00100,
    ST_WR_C = 5'b01000,
    ST_HOLD = 5'b10000
  } mm_state_e;

endpackage

// File: rtl/mm_addr_gen.sv
// mm_addr_gen: (outer, inner) index counter producing base + outer*N + inner.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         start a new sequence at (outer_init, 0) relative to base
//   step         advance inner, carrying into outer
//   single       1: sequence is one row (done at inner == N-1)
//                0: sequence is the whole matrix (done at (N-1, N-1))
//   base         base address latched on load
//   outer_init   starting outer index latched on load
//   outer, inner current indices (registered)
//   addr         address of the current indices (registered)
//   done         current indices are the last of the sequence
module mm_addr_gen
  import mm_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int ADDR_W = MM_ADDR_W,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              single,
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  outer_init,
  output logic [IDX_W-1:0]  outer,
  output logic [IDX_W-1:0]  inner,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] base_r;
  logic              single_r;
  logic [IDX_W-1:0]  outer_n;
  logic [IDX_W-1:0]  inner_n;
  logic [ADDR_W-1:0] addr_n;

  assign done = (inner == IDX_W'(N - 1)) && (single_r || (outer == IDX_W'(N - 1)));

  always_comb begin
    outer_n = outer;
    inner_n = inner;
    if (load) begin
      outer_n = outer_init;
      inner_n = '0;
    end else if (step) begin
      if (inner == IDX_W'(N - 1)) begin
        inner_n = '0;
        outer_n = outer + 1'b1;
      end else begin
        inner_n = inner + 1'b1;
      end
    end
    // Address is held in a register so mem_addr leaves the block glitch-free.
    addr_n = (load ? base : base_r) + ADDR_W'(outer_n) * ADDR_W'(N) + ADDR_W'(inner_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= '0;
      single_r <= 1'b0;
      outer    <= '0;
      inner    <= '0;
      addr     <= '0;
    end else begin
      if (load) begin
        base_r   <= base;
        single_r <= single;
      end
      if (load || step) begin
        outer <= outer_n;
        inner <= inner_n;
        addr  <= addr_n;
      end
    end
  end

endmodule

// File: rtl/mm_mem_sequencer.sv
// mm_mem_sequencer: memory-side sequencer of the matrix multiply accelerator.
// Owns the single-port operand/result SRAM and serves the controller's level
// requests fetch_A (one A row), fetch_B (all of B) and store_C (one C row).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start                              job start (IDLE only): clears row_idx, full
//   fetch_A/fetch_B/store_C            level requests
//   fetch_A_ready/fetch_B_ready/
//   store_C_ready                      done flags, held until request drops
//   full, row_idx                      C row bookkeeping
//   mem_en/mem_we/mem_addr/mem_wdata   SRAM command, mem_rdata read data (1-cycle latency)
//   a_valid/a_idx/a_data               A row element k to the row register
//   b_valid/b_row/b_col/b_data         B element to MAC b_col
//   c_idx, c_data                      MAC result mux select and result
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; start accepted here only
// RD_A    | issuing N reads of A row row_idx, then draining the last word
// RD_B    | issuing N*N reads of B row-major, then draining the last word
// WR_C    | writing N words of C row row_idx
// HOLD    | ready asserted until its request drops
module mm_mem_sequencer
  import mm_pkg::*;
#(
  parameter int N      = MM_N,
  parameter int DATA_W = MM_DATA_W,
  parameter int ADDR_W = MM_ADDR_W,
  parameter int A_BASE = 0,
  parameter int B_BASE = 16,
  parameter int C_BASE = 32,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fetch_A,
  input  logic              fetch_B,
  input  logic              store_C,
  output logic              fetch_A_ready,
  output logic              fetch_B_ready,
  output logic              store_C_ready,
  output logic              full,
  output logic [IDX_W-1:0]  row_idx,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              a_valid,
  output logic [IDX_W-1:0]  a_idx,
  output logic [DATA_W-1:0] a_data,
  output logic              b_valid,
  output logic [IDX_W-1:0]  b_row,
  output logic [IDX_W-1:0]  b_col,
  output logic [DATA_W-1:0] b_data,
  output logic [IDX_W-1:0]  c_idx,
  input  logic [DATA_W-1:0] c_data
);

  localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

  if (N < 2 || A_BASE + N * N > ADDR_SPAN || B_BASE + N * N > ADDR_SPAN ||
      C_BASE + N * N > ADDR_SPAN) begin : g_param_check
    $error("mm_mem_sequencer: N must be >= 2 and A, B, C must fit in ADDR_W bits");
  end

  mm_state_e         state, state_n;
  logic              mem_en_n, mem_we_n;
  logic              fetch_A_ready_n, fetch_B_ready_n, store_C_ready_n;
  logic              full_n;
  logic [IDX_W-1:0]  row_idx_n;
  logic [IDX_W-1:0]  row_base;

  logic              gen_load, gen_step, gen_single, gen_done;
  logic [ADDR_W-1:0] gen_base, gen_addr;
  logic [IDX_W-1:0]  gen_outer_init, gen_outer, gen_inner;

  mm_addr_gen #(.N(N), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gen_load),
    .step       (gen_step),
    .single     (gen_single),
    .base       (gen_base),
    .outer_init (gen_outer_init),
    .outer      (gen_outer),
    .inner      (gen_inner),
    .addr       (gen_addr),
    .done       (gen_done)
  );

  assign mem_addr  = gen_addr;
  assign c_idx     = gen_inner;
  assign mem_wdata = c_data;

  // The SRAM output register is the pipeline stage for read data; only the
  // valid/index shadow is registered here, qualified so idle data reads 0.
  assign a_data = a_valid ? mem_rdata : '0;
  assign b_data = b_valid ? mem_rdata : '0;

  always_comb begin
    state_n         = state;
    mem_en_n        = 1'b0;
    mem_we_n        = 1'b0;
    fetch_A_ready_n = fetch_A_ready;
    fetch_B_ready_n = fetch_B_ready;
    store_C_ready_n = store_C_ready;
    full_n          = full;
    row_idx_n       = row_idx;
    gen_load        = 1'b0;
    gen_step        = 1'b0;
    gen_single      = 1'b1;
    gen_base        = ADDR_W'(A_BASE);
    row_base        = start ? '0 : row_idx;
    gen_outer_init  = row_base;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          row_idx_n = '0;
          full_n    = 1'b0;
        end
        if (store_C && !store_C_ready) begin
          state_n  = ST_WR_C;
          gen_load = 1'b1;
          gen_base = ADDR_W'(C_BASE);
          mem_en_n = 1'b1;
          mem_we_n = 1'b1;
        end else if (fetch_A && !fetch_A_ready) begin
          state_n  = ST_RD_A;
          gen_load = 1'b1;
          mem_en_n = 1'b1;
        end else if (fetch_B && !fetch_B_ready) begin
          state_n        = ST_RD_B;
          gen_load       = 1'b1;
          gen_base       = ADDR_W'(B_BASE);
          gen_single     = 1'b0;
          gen_outer_init = '0;
          mem_en_n       = 1'b1;
        end
      end
      ST_RD_A, ST_RD_B: begin
        if (mem_en) begin
          gen_step = !gen_done;
          mem_en_n = !gen_done;
        end else begin
          // Issue phase over; this cycle carries the last read word.
          state_n = ST_HOLD;
          if (state == ST_RD_A) fetch_A_ready_n = 1'b1;
          else                  fetch_B_ready_n = 1'b1;
        end
      end
      ST_WR_C: begin
        if (!gen_done) begin
          gen_step = 1'b1;
          mem_en_n = 1'b1;
          mem_we_n = 1'b1;
        end else begin
          state_n         = ST_HOLD;
          store_C_ready_n = 1'b1;
          if (row_idx == IDX_W'(N - 1)) begin
            row_idx_n = '0;
            full_n    = 1'b1;
          end else begin
            row_idx_n = row_idx + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if ((fetch_A_ready && !fetch_A) || (fetch_B_ready && !fetch_B) ||
            (store_C_ready && !store_C)) begin
          state_n         = ST_IDLE;
          fetch_A_ready_n = 1'b0;
          fetch_B_ready_n = 1'b0;
          store_C_ready_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      fetch_A_ready <= 1'b0;
      fetch_B_ready <= 1'b0;
      store_C_ready <= 1'b0;
      full          <= 1'b0;
      row_idx       <= '0;
      a_valid       <= 1'b0;
      a_idx         <= '0;
      b_valid       <= 1'b0;
      b_row         <= '0;
      b_col         <= '0;
    end else begin
      state         <= state_n;
      mem_en        <= mem_en_n;
      mem_we        <= mem_we_n;
      fetch_A_ready <= fetch_A_ready_n;
      fetch_B_ready <= fetch_B_ready_n;
      store_C_ready <= store_C_ready_n;
      full          <= full_n;
      row_idx       <= row_idx_n;
      a_valid       <= (state == ST_RD_A) && mem_en;
      b_valid       <= (state == ST_RD_B) && mem_en;
      if ((state == ST_RD_A) && mem_en) a_idx <= gen_inner;
      if ((state == ST_RD_B) && mem_en) begin
        b_row <= gen_outer;
        b_col <= gen_inner;
      end
    end
  end

endmodule
